alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, shall set the operand and result width (legal values: powers of two, 8..64).
REQ-002 Parameter SHW = $clog2(WIDTH) shall be derived and used as the shift-amount width; it shall not be overridden.
REQ-003 CLK  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-004 RST  input  1  shall be the synchronous, active-high reset.
REQ-005 IN_VALID  input  1  shall indicate that SRC_A, SRC_B and ALU_CONTROL hold a valid request.
REQ-006 IN_READY  output  1  shall indicate that the block accepts a request this cycle.
REQ-007 SRC_A  input  WIDTH  shall be operand A.
REQ-008 SRC_B  input  WIDTH  shall be operand B.
REQ-009 ALU_CONTROL  input  4  shall be the opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low WIDTH bits), 11 DIVU, 12 REMU; 13-15 are illegal.
REQ-010 OUT_VALID  output  1  shall indicate that RES and ERR are valid.
REQ-011 OUT_READY  input  1  shall indicate that the consumer accepts the result.
REQ-012 RES  output  WIDTH  shall be the registered result.
REQ-013 ERR  output  1  shall flag an illegal opcode; it is valid only with OUT_VALID.

Function
REQ-014 A request shall transfer on any cycle where IN_VALID && IN_READY; a result shall transfer on any cycle where OUT_VALID && OUT_READY.
REQ-015 The FSM shall have exactly three states: IDLE, BUSY and DONE.
REQ-016 IN_READY shall equal (state == IDLE); in IDLE, OUT_VALID shall be 0.
REQ-017 IDLE with an accepted single-cycle or illegal op (0-9, 13-15) shall capture the result into RES and go to DONE, so OUT_VALID rises on the cycle after acceptance (latency 1).
REQ-018 IDLE with an accepted op 10-12 shall latch the operands, load an iteration counter with WIDTH, and go to BUSY.
REQ-019 In BUSY, each cycle shall perform one step (shift-add for MUL, restoring step for DIVU/REMU) and decrement the counter; when the counter reaches 0 the FSM shall load RES and go to DONE, giving OUT_VALID exactly WIDTH+1 cycles after acceptance.
REQ-020 In DONE, OUT_VALID shall be 1, and RES and ERR shall be held stable until OUT_READY; on OUT_READY the FSM shall go to IDLE (no same-cycle accept; maximum throughput is one request per 2 cycles).
REQ-021 While in BUSY or DONE, IN_VALID shall be ignored and SRC_A, SRC_B and ALU_CONTROL shall have no effect on RES.
REQ-022 ADD, SUB and MUL shall wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-023 SLL, SRL and SRA shall use SRC_B[SHW-1:0] as the shift amount; SRA shall replicate SRC_A[WIDTH-1].
REQ-024 SLT (signed) and SLTU (unsigned) shall return 1 when A < B and 0 otherwise, zero-extended to WIDTH.
REQ-025 DIVU by 0 shall return all ones; REMU by 0 shall return SRC_A; neither case shall set ERR or shorten the latency.
REQ-026 An illegal opcode shall return RES = 0 with ERR = 1; all legal ops shall return ERR = 0.

Reset
REQ-027 RST high at a clock edge shall force IDLE, IN_READY = 1, OUT_VALID = 0, RES = 0, ERR = 0, counter = 0, and shall take priority over all other inputs.
REQ-028 RST asserted in BUSY or DONE shall abort the operation with no result ever presented; the first request after reset release shall be accepted normally.

Verification
REQ-029 WIDTH=32, ADD with A=0xFFFFFFFF, B=1 -> RES=0x00000000 and ERR=0 one cycle after acceptance; SUB with A=0, B=1 -> RES=0xFFFFFFFF.
REQ-030 SRA with A=0x80000000, B=0x0000003F -> RES=0xFFFFFFFF; SLT with A=0xFFFFFFFF, B=1 -> RES=1; SLTU with the same operands -> RES=0.
REQ-031 MUL with A=0x00010000, B=0x00010001 -> RES=0x00010000 exactly 33 cycles after acceptance, with IN_READY=0 throughout.
REQ-032 DIVU with A=100, B=7 -> RES=14, and REMU with the same operands -> RES=2; DIVU with B=0 -> RES=0xFFFFFFFF, and REMU with A=5, B=0 -> RES=5.
REQ-033 Hold OUT_READY=0 for 5 cycles in DONE -> RES stable and OUT_VALID=1 throughout; ALU_CONTROL=14 -> RES=0 with ERR=1.
REQ-034 Assert RST mid-DIVU -> next cycle IDLE, OUT_VALID=0; a subsequent ADD 2+3 -> RES=5. Repeat REQ-029 to REQ-032 with WIDTH=8 (MUL latency 9 cycles).

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready handshake on both request and result.
//   Single-cycle ops (ADD..SLTU) and illegal opcodes produce a result one cycle
//   after acceptance. MUL, DIVU and REMU iterate one bit per cycle, producing a
//   result WIDTH+1 cycles after acceptance. Only one operation is in flight at a
//   time. The result is held until the consumer takes it.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   IN_VALID/IN_READY            request handshake (IN_READY == idle)
//   SRC_A, SRC_B [WIDTH]         operands
//   ALU_CONTROL [4]              opcode (0..12 legal, 13..15 illegal)
//   OUT_VALID/OUT_READY          result handshake
//   RES [WIDTH], ERR             registered result, illegal-opcode flag
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] SRC_A,
  input  logic [WIDTH-1:0] SRC_B,
  input  logic [3:0]       ALU_CONTROL,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RES,
  output logic             ERR
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0]   OP_MUL  = 4'd10;
  localparam logic [3:0]   OP_DIVU = 4'd11;
  localparam logic [3:0]   OP_REMU = 4'd12;
  localparam logic [SHW:0] CNT_W   = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_1   = (SHW+1)'(1);

  state_t           state, state_nx;
  logic [SHW:0]     cnt;
  logic [3:0]       op_q;
  // MUL: ra = shifted multiplicand, rb = shifted multiplier, racc = product.
  // DIV: ra = dividend shifting out / quotient shifting in, rb = divisor,
  //      racc = partial remainder.
  logic [WIDTH-1:0] ra, rb, racc;

  logic             is_long;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;

  logic [WIDTH-1:0] mul_nx, rem_nx, q_nx, long_res;
  logic [WIDTH:0]   r_sh, diff;
  logic             ge;

  assign is_long = (ALU_CONTROL >= OP_MUL) && (ALU_CONTROL <= OP_REMU);
  assign sh      = SRC_B[SHW-1:0];

  // single-cycle datapath
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (ALU_CONTROL)
      4'd0:    alu_res = SRC_A + SRC_B;
      4'd1:    alu_res = SRC_A - SRC_B;
      4'd2:    alu_res = SRC_A & SRC_B;
      4'd3:    alu_res = SRC_A | SRC_B;
      4'd4:    alu_res = SRC_A ^ SRC_B;
      4'd5:    alu_res = SRC_A << sh;
      4'd6:    alu_res = SRC_A >> sh;
      4'd7:    alu_res = WIDTH'($signed(SRC_A) >>> sh);
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, $signed(SRC_A) < $signed(SRC_B)};
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, SRC_A < SRC_B};
      4'd10, 4'd11, 4'd12: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // one iteration of shift-add multiply / restoring divide
  always_comb begin
    mul_nx = racc + (rb[0] ? ra : '0);
    r_sh   = {racc, ra[WIDTH-1]};
    diff   = r_sh - {1'b0, rb};
    // remainder < divisor keeps r_sh below 2*divisor, so diff's top bit is its sign
    ge     = ~diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
    q_nx   = {ra[WIDTH-2:0], ge};
    case (op_q)
      OP_MUL:  long_res = mul_nx;
      OP_DIVU: long_res = q_nx;
      default: long_res = rem_nx;
    endcase
  end

  // FSM
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_nx = is_long ? BUSY : DONE;
      end
      BUSY: if (cnt == CNT_1) state_nx = DONE;
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      op_q <= '0;
      ra   <= '0;
      rb   <= '0;
      racc <= '0;
      RES  <= '0;
      ERR  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (IN_VALID) begin
          if (is_long) begin
            ra   <= SRC_A;
            rb   <= SRC_B;
            racc <= '0;
            op_q <= ALU_CONTROL;
            cnt  <= CNT_W;
          end else begin
            RES <= alu_res;
            ERR <= alu_err;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_1;
          if (op_q == OP_MUL) begin
            racc <= mul_nx;
            ra   <= ra << 1;
            rb   <= rb >> 1;
          end else begin
            racc <= rem_nx;
            ra   <= q_nx;
          end
          // last iteration publishes its own step result directly
          if (cnt == CNT_1) begin
            RES <= long_res;
            ERR <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic        sel8;

  logic        v32, ir32, ov32, err32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  c32;

  logic        v8, ir8, ov8, err8;
  logic [7:0]  a8, b8, res8;
  logic [3:0]  c8;

  logic        ir_s, ov_s, err_s;
  logic [31:0] res_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut32 (
    .CLK(clk), .RST(rst), .IN_VALID(v32), .IN_READY(ir32),
    .SRC_A(a32), .SRC_B(b32), .ALU_CONTROL(c32),
    .OUT_VALID(ov32), .OUT_READY(out_ready), .RES(res32), .ERR(err32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .IN_VALID(v8), .IN_READY(ir8),
    .SRC_A(a8), .SRC_B(b8), .ALU_CONTROL(c8),
    .OUT_VALID(ov8), .OUT_READY(out_ready), .RES(res8), .ERR(err8)
  );

  assign ir_s  = sel8 ? ir8  : ir32;
  assign ov_s  = sel8 ? ov8  : ov32;
  assign err_s = sel8 ? err8 : err32;
  assign res_s = sel8 ? {24'h0, res8} : res32;

  // Issue one request to the selected DUT, wait (bounded) for the result, hold
  // OUT_READY low for 'hold' cycles, then consume. Returns what was seen.
  task automatic do_op(input bit s8, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold,
                       output logic [31:0] res, output logic err, output int lat,
                       output bit stable, output bit rdy_low);
    sel8 = s8;
    @(negedge clk);
    if (s8) begin v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; c8 = op; end
    else    begin v32 = 1'b1; a32 = a; b32 = b; c32 = op; end
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0; v32 = 1'b0;
    a8 = 8'h5a; b8 = 8'ha5; c8 = 4'd1;
    a32 = 32'hdead_beef; b32 = 32'h1234_5678; c32 = 4'd1;
    lat = 1; rdy_low = 1'b1;
    while (1) begin
      if (ir_s) rdy_low = 1'b0;
      if (ov_s || lat >= 200) break;
      @(negedge clk);
      lat++;
    end
    res = res_s; err = err_s; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (res_s !== res || err_s !== err || ov_s !== 1'b1) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if ({ir32, ov32, err32} !== 3'b100) begin bad++; $display("FAIL reset32 ctl got=%b want=100", {ir32, ov32, err32}); end
    total++; if (res32 !== 32'h0) begin bad++; $display("FAIL reset32 res got=%h want=0", res32); end
    total++; if ({ir8, ov8, err8, res8} !== {3'b100, 8'h00}) begin bad++; $display("FAIL reset8 got=%b %h want=100 00", {ir8, ov8, err8}, res8); end
  endtask

  // Single-cycle ops and illegal opcode, latency 1
  task automatic test_alu(input bit s8);
    logic [3:0]  op  [7] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd14, 4'd3};
    logic [31:0] a   [7] = '{32'hffffffff, 32'h0, 32'h80000000, 32'hffffffff, 32'hffffffff, 32'h1234, 32'hf0f0f0f0};
    logic [31:0] b   [7] = '{32'h1, 32'h1, 32'h3f, 32'h1, 32'h1, 32'h5678, 32'h0f0f0f0f};
    logic [31:0] e32 [7] = '{32'h0, 32'hffffffff, 32'hffffffff, 32'h1, 32'h0, 32'h0, 32'hffffffff};
    logic [31:0] e8  [7] = '{32'h0, 32'hff, 32'hff, 32'h1, 32'h0, 32'h0, 32'hff};
    logic [31:0] res; logic err; int lat; bit st, rl;
    if (s8) begin a[2] = 32'h80; b[3] = 32'h1; a[3] = 32'hff; a[4] = 32'hff; a[0] = 32'hff; a[6] = 32'hf0; b[6] = 32'h0f; end
    for (int i = 0; i < 7; i++) begin
      do_op(s8, op[i], a[i], b[i], 0, res, err, lat, st, rl);
      total++; if (res !== (s8 ? e8[i] : e32[i]) || err !== (op[i] == 4'd14) || lat !== 1)
        begin bad++; $display("FAIL alu w8=%0d op=%0d res=%h err=%b lat=%0d want res=%h err=%b lat=1",
                              s8, op[i], res, err, lat, s8 ? e8[i] : e32[i], op[i] == 4'd14); end
    end
  endtask

  // MUL/DIVU/REMU, latency WIDTH+1, IN_READY low throughout
  task automatic test_muldiv(input bit s8);
    logic [3:0]  op  [5] = '{4'd10, 4'd11, 4'd12, 4'd11, 4'd12};
    logic [31:0] a   [5] = '{32'h00010000, 32'd100, 32'd100, 32'd12345, 32'd5};
    logic [31:0] b   [5] = '{32'h00010001, 32'd7, 32'd7, 32'd0, 32'd0};
    logic [31:0] e32 [5] = '{32'h00010000, 32'd14, 32'd2, 32'hffffffff, 32'd5};
    logic [31:0] e8  [5] = '{32'h10, 32'd14, 32'd2, 32'hff, 32'd5};
    logic [31:0] res; logic err; int lat; bit st, rl;
    int want_lat;
    want_lat = s8 ? 9 : 33;
    if (s8) begin a[0] = 32'h10; b[0] = 32'h11; a[3] = 32'd200; end
    for (int i = 0; i < 5; i++) begin
      do_op(s8, op[i], a[i], b[i], 0, res, err, lat, st, rl);
      total++; if (res !== (s8 ? e8[i] : e32[i]) || err !== 1'b0)
        begin bad++; $display("FAIL muldiv w8=%0d op=%0d res=%h err=%b want res=%h err=0", s8, op[i], res, err, s8 ? e8[i] : e32[i]); end
      total++; if (lat !== want_lat || rl !== 1'b1)
        begin bad++; $display("FAIL muldiv_lat w8=%0d op=%0d lat=%0d ready_low=%b want lat=%0d ready_low=1", s8, op[i], lat, rl, want_lat); end
    end
  endtask

  task automatic test_hold;
    logic [31:0] res; logic err; int lat; bit st, rl;
    do_op(1'b0, 4'd4, 32'hff00ff00, 32'h0ff00ff0, 5, res, err, lat, st, rl);
    total++; if (res !== 32'hf0f0f0f0 || st !== 1'b1)
      begin bad++; $display("FAIL hold_xor res=%h stable=%b want res=f0f0f0f0 stable=1", res, st); end
    do_op(1'b0, 4'd14, 32'h1, 32'h2, 5, res, err, lat, st, rl);
    total++; if (res !== 32'h0 || err !== 1'b1 || st !== 1'b1)
      begin bad++; $display("FAIL hold_illegal res=%h err=%b stable=%b want 0 1 1", res, err, st); end
    // back-to-back: next request after a consume
    do_op(1'b0, 4'd5, 32'h1, 32'h24, 0, res, err, lat, st, rl);
    total++; if (res !== 32'h10 || err !== 1'b0)
      begin bad++; $display("FAIL b2b_sll res=%h err=%b want 00000010 0", res, err); end
  endtask

  task automatic test_abort;
    logic [31:0] res; logic err; int lat; bit st, rl;
    bit seen;
    sel8 = 1'b0;
    @(negedge clk);
    v32 = 1'b1; a32 = 32'd100; b32 = 32'd7; c32 = 4'd11;
    @(negedge clk);
    v32 = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (ir32 !== 1'b0) begin bad++; $display("FAIL abort_busy in_ready=%b want 0", ir32); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if ({ir32, ov32, res32} !== {2'b10, 32'h0})
      begin bad++; $display("FAIL abort_reset in_ready=%b out_valid=%b res=%h want 1 0 0", ir32, ov32, res32); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ov32) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_result out_valid seen=%b want 0", seen); end
    do_op(1'b0, 4'd0, 32'd2, 32'd3, 0, res, err, lat, st, rl);
    total++; if (res !== 32'd5 || err !== 1'b0 || lat !== 1)
      begin bad++; $display("FAIL abort_add res=%h err=%b lat=%0d want 5 0 1", res, err, lat); end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; sel8 = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0; c32 = '0;
    v8  = 1'b0; a8  = '0; b8  = '0; c8  = '0;
    test_reset;
    test_alu(1'b0);
    test_muldiv(1'b0);
    test_hold;
    test_abort;
    test_alu(1'b1);
    test_muldiv(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
